// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic datapath blocks.
//   - FSM state encoding for the bit-serial adder (S_IDLE/S_RUN/S_DONE)
//   - generic valid/ready handshake pair
//   - cnt_width(): bit-counter width for a WIDTH-bit serial operation
// ----------------------------------------------------------------------------
package arith_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } serial_state_t;

   typedef struct packed {
      logic valid;
      logic ready;
   } hs_t;

   // A 1-bit operand still needs a 1-bit counter, so clamp at 1.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// ----------------------------------------------------------------------------
// serial_fa_cell
// Combinational full adder assembled from two half-add stages plus an OR.
// Ports:
//   i_x, i_y  in   operand bits
//   i_ci      in   carry in
//   o_s       out  sum bit      = x ^ y ^ ci
//   o_co      out  carry out    = (x & y) | ((x ^ y) & ci)
// ----------------------------------------------------------------------------
module serial_fa_cell (
   input  logic i_x,
   input  logic i_y,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);

   logic w_hs1_s, w_hs1_c;
   logic w_hs2_s, w_hs2_c;

   // first half-add: operand bits
   assign w_hs1_s = i_x ^ i_y;
   assign w_hs1_c = i_x & i_y;

   // second half-add: partial sum with incoming carry
   assign w_hs2_s = w_hs1_s ^ i_ci;
   assign w_hs2_c = w_hs1_s & i_ci;

   assign o_s  = w_hs2_s;
   assign o_co = w_hs1_c | w_hs2_c;

endmodule

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial, LSB-first adder: sum = a + b + cin (mod 2^WIDTH), cout = carry
// out of bit WIDTH-1. One result bit per clock, valid/ready on both sides,
// no overlap between operations.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (sum, cout)
// ----------------------------------------------------------------------------
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = cnt_width(WIDTH);

   serial_state_t    r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum;
   logic             r_carry, r_cout;

   logic             w_accept, w_last, w_s, w_c;
   logic [WIDTH:0]   w_sum_cat;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // handshake outputs are pure functions of the state register
   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);

   assign w_accept = in_ready && in_valid;
   assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

   // ---------------- datapath ----------------
   serial_fa_cell u_fa (
      .i_x  (r_a_sh[0]),
      .i_y  (r_b_sh[0]),
      .i_ci (r_carry),
      .o_s  (w_s),
      .o_co (w_c)
   );

   // new bit enters at the MSB; concatenation keeps WIDTH=1 legal
   assign w_sum_cat = {w_s, r_sum};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a_sh  <= a;
         r_b_sh  <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_carry <= w_c;
         r_cnt   <= r_cnt + CNT_W'(1);
         r_sum   <= w_sum_cat[WIDTH:1];
         if (w_last) r_cout <= w_c;
      end
   end

   // sum/cout are held outside RUN, so they keep the last result in IDLE
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic         rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout;
   logic [W-1:0] a, b, sum;
   // WIDTH=1 instance
   logic         rst1_n, iv1, ir1, ov1, or1, cin1, cout1;
   logic [0:0]   a1, b1, sum1;

   int n_vec = 0;
   int n_err = 0;

   serial_adder #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
      .sum(sum1), .cout(cout1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full transaction on the WIDTH=8 instance. noise=1 keeps in_valid high
   // with unrelated operands while the block is busy.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input int stall, input bit noise);
      logic [8:0] ref_v;
      int k;
      ref_v = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
      k = 0;
      while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
      chk("in_ready_idle", in_ready, 1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;                 // accept edge
      if (noise) begin a = ~ta; b = ta ^ 8'h5A; cin = ~tc; end
      else in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1; k++;
      end
      chk("latency", k, W);
      chk("sum", sum, ref_v[7:0]);
      chk("cout", cout, ref_v[8]);
      chk("in_ready_done", in_ready, 0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", out_valid, 1);
         chk("stall_sum", {cout, sum}, ref_v);
         chk("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
      chk("hold_after_done", {cout, sum}, ref_v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] e1;
      int k;
      bit any_ov;
      rst_n = 0; rst1_n = 0;
      in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
      iv1 = 0; or1 = 0; a1 = '0; b1 = '0; cin1 = 0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst1_in_ready", ir1, 1);
      chk("rst1_out_valid", ov1, 0);
      @(negedge clk); rst_n = 1; rst1_n = 1;
      @(posedge clk); #1;

      // directed cases
      run_op(8'hFF, 8'h01, 1'b0, 0, 0);
      run_op(8'h3C, 8'h42, 1'b1, 0, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 0, 0);
      run_op(8'h00, 8'h00, 1'b0, 0, 0);
      // backpressure with a competing request during the stall
      run_op(8'hA5, 8'h5B, 1'b0, 20, 1);
      // in_valid toggled with different operands during RUN
      run_op(8'h12, 8'h34, 1'b1, 2, 1);

      // randomized
      for (int n = 0; n < 30; n++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

      // reset in RUN cycle 3 aborts
      a = 8'hC3; b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      @(negedge clk); rst_n = 1'b1;
      any_ov = 0;
      repeat (W + 4) begin @(posedge clk); #1; if (out_valid) any_ov = 1; end
      chk("abort_no_pulse", any_ov, 0);
      chk("abort_sum_after", sum, 0);
      run_op(8'h80, 8'h80, 1'b0, 1, 0);

      // WIDTH=1 exhaustive
      for (int i = 0; i < 8; i++) begin
         a1[0] = i[0]; b1[0] = i[1]; cin1 = i[2];
         e1 = {1'b0, i[0]} + {1'b0, i[1]} + {1'b0, i[2]};
         iv1 = 1'b1;
         @(posedge clk); #1; iv1 = 1'b0;
         k = 0;
         while (!ov1 && k < 10) begin @(posedge clk); #1; k++; end
         chk("w1_latency", k, 1);
         chk("w1_sum", sum1, e1[0]);
         chk("w1_cout", cout1, e1[1]);
         or1 = 1'b1;
         @(posedge clk); #1; or1 = 1'b0;
         chk("w1_release", ov1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
